// File: rtl/risc_mc_pkg.sv
// risc_mc_pkg
//   Shared types and encodings for the multicycle RV32-subset controller:
//   FSM state enum, opcode constants, datapath mux/ALU encodings, error
//   codes, and small decode helpers used by the controller and its ALU
//   decoder.
package risc_mc_pkg;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Immediate format follows the opcode; anything unrecognised falls back
    // to I, which is also the format of OP-IMM and LOAD.
    function automatic logic [1:0] imm_sel(input logic [6:0] opc);
        case (opc)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    // Shared funct3 -> ALU op map for R and I arithmetic; bit 3 flags an
    // unsupported funct3.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return {1'b0, ALU_ADD};
            3'b001:  return {1'b0, ALU_SLL};
            3'b101:  return {1'b0, ALU_SRL};
            3'b110:  return {1'b0, ALU_OR};
            3'b111:  return {1'b0, ALU_AND};
            default: return {1'b1, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/risc_multicycle_controller_alu_decoder.sv
// risc_alu_decoder
//   Combinational instruction-field decoder: produces the ALU operation for
//   R/I arithmetic and flags any instruction outside the supported subset.
//   Ports:
//     i_opcode  [6:0]  IR[6:0]
//     i_funct3  [2:0]  IR[14:12]
//     i_funct7  [6:0]  IR[31:25]
//     o_alu_op  [2:0]  ALU operation (ADD for non-arithmetic opcodes)
//     o_illegal        instruction not in the supported subset
module risc_alu_decoder
    import risc_mc_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic [2:0] o_alu_op,
    output logic       o_illegal
);

    logic [3:0] w_f3_dec;

    assign w_f3_dec = alu_from_f3(i_funct3);

    always_comb begin
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_R: begin
                // SUB is the only alternate-funct7 encoding supported.
                if (i_funct7 == F7_ALT && i_funct3 == 3'b000) begin
                    o_alu_op = ALU_SUB;
                end else if (i_funct7 == F7_BASE) begin
                    o_alu_op  = w_f3_dec[2:0];
                    o_illegal = w_f3_dec[3];
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_I: begin
                o_alu_op  = w_f3_dec[2:0];
                o_illegal = w_f3_dec[3];
            end
            OP_LOAD, OP_STORE: o_illegal = (i_funct3 != 3'b010);
            OP_BRANCH:         o_illegal = (i_funct3[2:1] != 2'b00);
            OP_JAL:            o_illegal = 1'b0;
            default:           o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc_multicycle_controller.sv
// risc_multicycle_controller
//   Sequencer for the shared-memory multicycle RV32-subset datapath.
//   Memory handshake: mem_read/mem_write are requests held stable from the
//   first cycle of FETCH/MEMREAD/MEMWRITE until the cycle in which
//   mem_ready is high; that cycle completes the transfer. mem_ready is
//   ignored in every other state. A request that waits MEM_TIMEOUT cycles
//   without mem_ready parks the core in TRAP with err_code=10.
//   Ports:
//     clk, nrst                  clock, async active-low reset
//     opcode/funct3/funct7       instruction fields from IR
//     zero                       ALU zero flag
//     mem_ready                  memory completes current request
//     mem_read, mem_write        memory requests
//     adr_src, ir_write, pc_write, reg_write, alu_src_a, alu_src_b,
//     alu_op, imm_src, result_src  datapath controls
//     instr_done                 retire pulse
//     err_code                   sticky error code
//     dbg_state                  current FSM state
module risc_multicycle_controller
    import risc_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] imm_src,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic [1:0] err_code,
    output state_t     dbg_state
);

    // Count value in the last permitted waiting cycle.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    logic [7:0] r_wait_cnt;
    logic [1:0] r_err;
    logic [2:0] w_dec_op;
    logic       w_illegal;
    logic       w_waiting;
    logic       w_timeout;

    risc_alu_decoder u_alu_decoder (
        .i_opcode  (opcode),
        .i_funct3  (funct3),
        .i_funct7  (funct7),
        .o_alu_op  (w_dec_op),
        .o_illegal (w_illegal)
    );

    assign w_waiting = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                       (r_state == S_MEMWRITE);
    // mem_ready in the limit cycle still completes the transfer.
    assign w_timeout = w_waiting && !mem_ready && (r_wait_cnt == TO_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_START;
            r_wait_cnt <= '0;
            r_err      <= ERR_NONE;
        end else begin
            // Any exit from a waiting state, or any non-waiting state,
            // leaves the counter at zero for the next request.
            if (w_waiting && !mem_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (w_timeout) begin
                r_state <= S_TRAP;
                r_err   <= ERR_TIMEOUT;
            end else begin
                case (r_state)
                    S_START:  r_state <= S_FETCH;
                    S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                    S_DECODE: begin
                        if (w_illegal) begin
                            r_state <= S_TRAP;
                            r_err   <= ERR_ILLEGAL;
                        end else begin
                            case (opcode)
                                OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                                OP_R:              r_state <= S_EXECR;
                                OP_I:              r_state <= S_EXECI;
                                OP_BRANCH:         r_state <= S_BRANCH;
                                OP_JAL:            r_state <= S_JAL;
                                default: begin
                                    r_state <= S_TRAP;
                                    r_err   <= ERR_ILLEGAL;
                                end
                            endcase
                        end
                    end
                    S_MEMADR:   r_state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
                    S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
                    S_MEMWB:    r_state <= S_FETCH;
                    S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
                    S_EXECR:    r_state <= S_ALUWB;
                    S_EXECI:    r_state <= S_ALUWB;
                    S_ALUWB:    r_state <= S_FETCH;
                    S_BRANCH:   r_state <= S_FETCH;
                    S_JAL:      r_state <= S_ALUWB;
                    S_TRAP:     r_state <= S_TRAP;
                    default:    r_state <= S_START;
                endcase
            end
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        instr_done = 1'b0;
        if (r_state != S_START && r_state != S_TRAP) begin
            imm_src = imm_sel(opcode);
        end
        case (r_state)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // ALUOut captures OldPC + imm: the branch/jump target.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = w_dec_op;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = w_dec_op;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALU_SUB;
                // funct3[0] selects bne; only 000/001 reach this state.
                pc_write   = funct3[0] ? !zero : zero;
                instr_done = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_code  = r_err;
    assign dbg_state = r_state;

endmodule
